// File: rtl/regfile_sb.sv
// Integer register file with two registered read ports, one write port and a
// per-register busy scoreboard used by issue logic to detect RAW hazards.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush
);
    logic [XLEN-1:0]     mem_q [NUM_REGS];
    logic [XLEN-1:0]     mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] wr_hit;
    logic                wr_ok;

    logic [ADDR_W-1:0]   rd_addr   [2];
    logic [XLEN-1:0]     rd_data_q [2];
    logic [XLEN-1:0]     rd_data_d [2];
    logic [1:0]          rd_busy_q;
    logic [1:0]          rd_busy_d;

    // Only implemented, nonzero registers ever decode a hit, so out-of-range
    // and x0 writes/reservations fall through without extra range checks.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wr_hit[gi] = 1'b0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_live
                logic rsv_hit;
                assign wr_hit[gi] = we && (wr_addr == ADDR_W'(gi));
                assign rsv_hit    = rsv_en && (rsv_addr == ADDR_W'(gi));
                // A new reservation outranks a completing writeback.
                assign busy_d[gi] = flush      ? 1'b0 :
                                    rsv_hit    ? 1'b1 :
                                    wr_hit[gi] ? 1'b0 : busy_q[gi];
            end
        end
    endgenerate

    assign wr_ok      = |wr_hit;
    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = wr_hit[i] ? wr_data : mem_q[i];
        end
    end

    // Busy flag reported is the post-update value so it lines up with the
    // register state visible the cycle after the read.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_d[p] = rd_data_q[p];
            rd_busy_d[p] = rd_busy_q[p];
            if (rd_en) begin
                rd_data_d[p] = '0;
                rd_busy_d[p] = 1'b0;
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (rd_addr[p] == ADDR_W'(i)) begin
                        rd_data_d[p] = mem_q[i];
                        rd_busy_d[p] = busy_d[i];
                    end
                end
                if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p])) begin
                    rd_data_d[p] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q       <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_busy_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q       <= busy_d;
            rd_data_q[0] <= rd_data_d[0];
            rd_data_q[1] <= rd_data_d[1];
            rd_busy_q    <= rd_busy_d;
        end
    end

    assign rs1_data = rd_data_q[0];
    assign rs2_data = rd_data_q[1];
    assign rs1_busy = rd_busy_q[0];
    assign rs2_busy = rd_busy_q[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: instance A is 32 regs write-first, instance B is 16 regs
// read-first; both see identical stimulus and are checked against hand values.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, wr_addr = '0, rsv_addr = '0;
    logic        we = 1'b0, rsv_en = 1'b0, flush = 1'b0;
    logic [31:0] wr_data = '0;

    logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regfile_sb #(.XLEN(32), .ADDR_W(5), .NUM_REGS(16), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] a1d; logic a1b; logic [31:0] a2d; logic a2b;
        logic [31:0] b1d; logic b1b; logic [31:0] b2d; logic b2b;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic w, input logic [4:0] wa, input logic [31:0] wd,
        input logic r, input logic [4:0] ra, input logic f,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [31:0] a1d, input logic a1b, input logic [31:0] a2d, input logic a2b,
        input logic [31:0] b1d, input logic b1b, input logic [31:0] b2d, input logic b2b);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.rsv = r; v.ra = ra; v.fl = f;
        v.r1 = r1; v.r2 = r2;
        v.a1d = a1d; v.a1b = a1b; v.a2d = a2d; v.a2b = a2b;
        v.b1d = b1d; v.b1b = b1b; v.b2d = b2d; v.b2b = b2b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag,
        input logic [31:0] a1d, input logic a1b, input logic [31:0] a2d, input logic a2b,
        input logic [31:0] b1d, input logic b1b, input logic [31:0] b2d, input logic b2b);
        chk({tag, " A.rs1_data"}, a_rs1_data, a1d);
        chk({tag, " A.rs1_busy"}, 32'(a_rs1_busy), 32'(a1b));
        chk({tag, " A.rs2_data"}, a_rs2_data, a2d);
        chk({tag, " A.rs2_busy"}, 32'(a_rs2_busy), 32'(a2b));
        chk({tag, " B.rs1_data"}, b_rs1_data, b1d);
        chk({tag, " B.rs1_busy"}, 32'(b_rs1_busy), 32'(b1b));
        chk({tag, " B.rs2_data"}, b_rs2_data, b2d);
        chk({tag, " B.rs2_busy"}, 32'(b_rs2_busy), 32'(b2b));
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic r, input logic [4:0] ra, input logic f,
                         input logic re, input logic [4:0] a1, input logic [4:0] a2);
        we = w; wr_addr = wa; wr_data = wd;
        rsv_en = r; rsv_addr = ra; flush = f;
        rd_en = re; rs1_addr = a1; rs2_addr = a2;
    endtask

    initial begin
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0,  0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 5, 0,  32'hDEADBEEF, 0, 0, 0,  32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h12345678, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 5,  0, 0, 32'hDEADBEEF, 0,  0, 0, 32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 4, 32'h44, 0, 0, 0, 4, 4,  32'h44, 0, 32'h44, 0,  0, 0, 0, 0);
        vecs[5]  = mk(1, 20, 32'hFF, 0, 0, 0, 20, 4,  32'hFF, 0, 32'h44, 0,  0, 0, 32'h44, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 20, 4,  32'hFF, 0, 32'h44, 0,  0, 0, 32'h44, 0);
        vecs[7]  = mk(0, 0, 0, 1, 7, 0, 7, 7,  0, 1, 0, 1,  0, 1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 7, 7,  0, 1, 0, 1,  0, 1, 0, 1);
        vecs[9]  = mk(1, 7, 32'h55, 0, 0, 0, 7, 7,  32'h55, 0, 32'h55, 0,  0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 7, 7,  32'h55, 0, 32'h55, 0,  32'h55, 0, 32'h55, 0);
        vecs[11] = mk(1, 7, 32'h66, 1, 7, 0, 7, 7,  32'h66, 1, 32'h66, 1,  32'h55, 1, 32'h55, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 7, 7,  32'h66, 1, 32'h66, 1,  32'h66, 1, 32'h66, 1);
        vecs[13] = mk(0, 0, 0, 1, 3, 0, 3, 7,  0, 1, 32'h66, 1,  0, 1, 32'h66, 1);
        vecs[14] = mk(0, 0, 0, 1, 4, 0, 4, 3,  32'h44, 1, 0, 1,  32'h44, 1, 0, 1);
        vecs[15] = mk(0, 0, 0, 1, 9, 0, 9, 4,  0, 1, 32'h44, 1,  0, 1, 32'h44, 1);
        vecs[16] = mk(1, 3, 32'hA, 0, 0, 1, 3, 9,  32'hA, 0, 0, 0,  0, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 3, 4,  32'hA, 0, 32'h44, 0,  32'hA, 0, 32'h44, 0);
        vecs[18] = mk(0, 0, 0, 1, 15, 0, 15, 16,  0, 1, 0, 0,  0, 1, 0, 0);
        vecs[19] = mk(0, 0, 0, 1, 16, 0, 16, 16,  0, 1, 0, 1,  0, 0, 0, 0);
        vecs[20] = mk(1, 16, 32'h16, 0, 0, 0, 16, 15,  32'h16, 0, 0, 1,  0, 0, 0, 1);

        // Outputs must be zero while reset is held.
        #12;
        chk_all("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 5'(a), 5'(31 - a));
            @(posedge clk); #1;
            $display("reset read rs1=x%0d rs2=x%0d", a, 31 - a);
            chk_all("reset_read", 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rsv, vecs[i].ra,
                  vecs[i].fl, 1, vecs[i].r1, vecs[i].r2);
            @(posedge clk); #1;
            $display("vec %0d: we=%0b x%0d=0x%0h rsv=%0b x%0d flush=%0b rd x%0d x%0d -> A %0h/%0b %0h/%0b B %0h/%0b %0h/%0b",
                     i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rsv, vecs[i].ra, vecs[i].fl,
                     vecs[i].r1, vecs[i].r2, a_rs1_data, a_rs1_busy, a_rs2_data, a_rs2_busy,
                     b_rs1_data, b_rs1_busy, b_rs2_data, b_rs2_busy);
            chk_all($sformatf("vec%0d", i), vecs[i].a1d, vecs[i].a1b, vecs[i].a2d, vecs[i].a2b,
                    vecs[i].b1d, vecs[i].b1b, vecs[i].b2d, vecs[i].b2b);
            @(negedge clk);
        end

        // Stall: outputs hold while writes and reservations still land.
        drive(1, 2, 32'h11, 0, 0, 0, 1, 9, 7);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 2, 7);
        @(posedge clk); #1;
        $display("stall: read x2 before stall");
        chk_all("stall_pre", 32'h11, 0, 32'h66, 0, 32'h11, 0, 32'h66, 0);
        @(negedge clk);
        drive(1, 2, 32'h22, 1, 3, 0, 0, 5, 3);
        @(posedge clk); #1;
        $display("stall: rd_en=0 with write x2 and reserve x3");
        chk_all("stall_hold", 32'h11, 0, 32'h66, 0, 32'h11, 0, 32'h66, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 2, 3);
        @(posedge clk); #1;
        $display("stall: rd_en=1 again");
        chk_all("stall_post", 32'h22, 0, 32'hA, 1, 32'h22, 0, 32'hA, 1);
        @(negedge clk);

        // Asynchronous reset mid-run with an in-flight write to x6.
        drive(1, 6, 32'h77, 0, 0, 0, 1, 6, 2);
        #1;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted between edges");
        chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 6, 3);
        @(posedge clk); #1;
        $display("after reset: read x6 x3");
        chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in register scoreboard. Provides two synchronous read ports, one write port, optional write-first bypass, and a per-register busy bit that tracks outstanding writebacks. Sits between decode/issue and writeback in the pipelined core. Replaces the fixed 16-entry register file and lets issue logic detect RAW hazards without a separate scoreboard.

## Interface

Parameters:
- XLEN, 32, data width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, implemented registers; 2 ≤ NUM_REGS ≤ 2^ADDR_W.
- BYPASS, 1, when 1 a same-cycle write is forwarded to reads (write-first); when 0 reads return the old value (read-first).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- rd_en, input, 1, when 1 the read outputs update at the clock edge; when 0 they hold (stall).
- rs1_addr, input, ADDR_W, read port A address.
- rs2_addr, input, ADDR_W, read port B address.
- rs1_data, output, XLEN, registered read data A.
- rs2_data, output, XLEN, registered read data B.
- rs1_busy, output, 1, registered busy flag for rs1_addr.
- rs2_busy, output, 1, registered busy flag for rs2_addr.
- we, input, 1, write enable.
- wr_addr, input, ADDR_W, write address.
- wr_data, input, XLEN, write data.
- rsv_en, input, 1, reserve: mark rsv_addr busy (instruction issued).
- rsv_addr, input, ADDR_W, destination being reserved.
- flush, input, 1, clear every busy bit (pipeline flush).

## Operation

- Storage is NUM_REGS × XLEN. Register 0 is hardwired: it reads 0, ignores writes, and is never busy.
- Addresses ≥ NUM_REGS are out of range. Reads return data 0 and busy 0. Writes and reservations to them are ignored.
- Write: if we and wr_addr is valid and nonzero, then mem[wr_addr] ← wr_data at the edge.
- Busy next-state, per register r ≠ 0, in priority order:
  - flush → 0.
  - rsv_en && rsv_addr==r → 1.
  - we && wr_addr==r → 0.
  - otherwise hold.
- Reserve beats writeback to the same register in the same cycle, because a new producer is outstanding.
- flush does not cancel a same-cycle write; the data write still occurs.
- Read, when rd_en=1:
  - rsN_data ← wr_data if BYPASS and we and wr_addr==rsN_addr (valid, nonzero); otherwise mem[rsN_addr] (0 for x0 or out of range).
  - rsN_busy ← busy next-state of rsN_addr. This applies for both BYPASS settings, so the flag always matches the cycle after the update.
- Both read ports may address the same register. Each resolves independently and identically.

## Timing

- Read latency is 1 cycle: the address is sampled at edge k and data and busy are valid after edge k.
- Write latency is 1 cycle: a read issued the cycle after the write returns new data regardless of BYPASS.
- With rd_en=0, rs1_data, rs2_data, rs1_busy and rs2_busy hold their previous values. Writes and busy updates still proceed.
- Reset (rst_n=0, asynchronous): all mem entries, all busy bits, rs1_data, rs2_data, rs1_busy and rs2_busy go to 0 immediately. They stay there until the first rising edge after deassertion.
- Reset mid-operation aborts any in-flight write; that write is not committed.
- All inputs are sampled only on the rising edge of clk. There are no combinational input-to-output paths.

## Test plan

- Reset, then read every address on both ports → all data 0 and all busy 0. Asserting rst_n=0 mid-run with nonzero contents → outputs 0 before the next edge.
- Write x5=0xDEADBEEF, reading x5 in the same cycle:
  - BYPASS=1 → rs1_data=0xDEADBEEF.
  - BYPASS=0 → rs1_data=0.
  - Next cycle → 0xDEADBEEF in both configurations.
- Write x0=0x12345678 and reserve x0 → x0 reads 0 and busy 0. With NUM_REGS=16 and ADDR_W=5, write x20=0xFF → x20 reads 0 and x4 is unchanged.
- Scoreboard sequence:
  - Reserve x7 → rs1_busy=1 on the next read.
  - Write x7=0x55 → busy 0 and data 0x55.
  - Reserve x7 and write x7=0x66 in the same cycle → busy 1 and data 0x66 (BYPASS=1).
- Reserve x3, x4 and x9, then flush together with a write x3=0xA → all busy 0 and x3 reads 0xA.
- Read x2 with rd_en=1 and get 0x11. Drop rd_en, write x2=0x22 and change rs1_addr → rs1_data holds 0x11. Raise rd_en → 0x22.
